mack_irq_ctrl: RTL

- Interrupt controller and bus-cycle supervisor for the 68000 system. It sits directly upstream of the address decoder.
- Prioritises seven active-low interrupt requests onto IPL[2:0]. The timer is one source; the MFP is another.
- Detects interrupt-acknowledge cycles and drives IACK_CYC to the decoder's IACK input. Asserts VPA only for levels configured as autovectored. Asserts a per-level acknowledge strobe for vectored devices.
- Watchdogs every bus cycle and asserts BERR when nothing terminates it.

---
 rtl/mack_irq_ctrl_if.sv | 35 +++
 rtl/mack_irq_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mack_irq_ctrl_if.sv
// ============================================================================
// Module   : mack_irq_ctrl_if
// Purpose  : CPU-side bus bundle between the 68000 and the interrupt/bus
//            supervisor (requests, strobes, acknowledges, terminations).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mack_irq_ctrl_if;
    logic [6:0] IRQ_N;
    logic       AS;
    logic [2:0] FC;
    logic [3:0] ADDR_HI;
    logic [2:0] ADDR_LO;
    logic       DTACK_IN;
    logic [2:0] IPL;
    logic       VPA;
    logic [6:0] IACK_N;
    logic       IACK_CYC;
    logic       BERR;

    // Controller side
    modport slave (
        input  IRQ_N, AS, FC, ADDR_HI, ADDR_LO, DTACK_IN,
        output IPL, VPA, IACK_N, IACK_CYC, BERR
    );

    // CPU / system side
    modport master (
        output IRQ_N, AS, FC, ADDR_HI, ADDR_LO, DTACK_IN,
        input  IPL, VPA, IACK_N, IACK_CYC, BERR
    );
endinterface

`default_nettype wire

// File: rtl/mack_irq_ctrl.sv
// ============================================================================
// Module   : mack_irq_ctrl
// Purpose  : 68000 interrupt priority encoder, IACK cycle handler and
//            bus-cycle watchdog raising BERR on unterminated cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mack_irq_ctrl #(
    parameter logic [6:0] AUTOVEC_MASK = 7'b0000010,
    parameter int         BERR_TIMEOUT = 64
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    mack_irq_ctrl_if.slave bus
);

    localparam int                c_wd_w       = $clog2(BERR_TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last    = c_wd_w'(BERR_TIMEOUT - 1);
    localparam logic [c_wd_w-1:0] c_wd_max     = {c_wd_w{1'b1}};
    localparam logic [7:0]        c_auto_mask8 = {AUTOVEC_MASK, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IACK  = 2'd1,
        ST_CYCLE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        irq_s1_q, irq_s1_d;
    logic [6:0]        irq_s2_q, irq_s2_d;
    logic [2:0]        lvl_q, lvl_d;
    logic [c_wd_w-1:0] wd_q, wd_d;
    logic [2:0]        ipl_q, ipl_d;
    logic              vpa_q, vpa_d;
    logic [6:0]        iack_n_q, iack_n_d;
    logic              iack_cyc_q, iack_cyc_d;
    logic              berr_q, berr_d;

    logic [2:0]        cur_lvl;
    logic [2:0]        lvl_src;
    logic              ack_auto;
    logic [7:0]        ack_onehot;
    logic [6:0]        ack_strobe_n;
    logic              iack_space;

    always_comb begin
        irq_s1_d = bus.IRQ_N;
        irq_s2_d = irq_s1_q;

        // Later (higher) indices overwrite, so level 7 wins
        cur_lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (!irq_s2_q[i]) begin
                cur_lvl = 3'(i + 1);
            end
        end
        ipl_d = ~cur_lvl;

        // In IDLE the level comes straight off the bus; afterwards from the latch
        lvl_src      = (state_q == ST_IDLE) ? bus.ADDR_LO : lvl_q;
        ack_auto     = c_auto_mask8[lvl_src];
        ack_onehot   = 8'd1 << lvl_src;
        ack_strobe_n = ack_auto ? 7'h7F : ~ack_onehot[7:1];
        iack_space   = (bus.FC == 3'b111) && (bus.ADDR_HI == 4'hF);

        state_d    = state_q;
        lvl_d      = lvl_q;
        wd_d       = wd_q;
        vpa_d      = vpa_q;
        iack_n_d   = iack_n_q;
        iack_cyc_d = iack_cyc_q;
        berr_d     = berr_q;

        if (bus.AS) begin
            state_d    = ST_IDLE;
            vpa_d      = 1'b1;
            iack_n_d   = 7'h7F;
            iack_cyc_d = 1'b1;
            berr_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wd_d = '0;
                    if (iack_space) begin
                        lvl_d      = bus.ADDR_LO;
                        iack_cyc_d = 1'b0;
                        if (bus.ADDR_LO == 3'd0) begin
                            berr_d  = 1'b0;
                            state_d = ST_FAULT;
                        end else begin
                            vpa_d    = ~ack_auto;
                            iack_n_d = ack_strobe_n;
                            state_d  = ST_IACK;
                        end
                    end else begin
                        state_d = ST_CYCLE;
                    end
                end
                ST_IACK, ST_CYCLE: begin
                    if (state_q == ST_IACK) begin
                        vpa_d    = ~ack_auto;
                        iack_n_d = ack_strobe_n;
                    end
                    // A sampled DTACK or our own VPA freezes the watchdog
                    if (bus.DTACK_IN && vpa_q) begin
                        if (wd_q == c_wd_last) begin
                            berr_d  = 1'b0;
                            state_d = ST_FAULT;
                        end else if (wd_q != c_wd_max) begin
                            wd_d = wd_q + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    berr_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            irq_s1_q   <= 7'h7F;
            irq_s2_q   <= 7'h7F;
            lvl_q      <= 3'd0;
            wd_q       <= '0;
            ipl_q      <= 3'b111;
            vpa_q      <= 1'b1;
            iack_n_q   <= 7'h7F;
            iack_cyc_q <= 1'b1;
            berr_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            irq_s1_q   <= irq_s1_d;
            irq_s2_q   <= irq_s2_d;
            lvl_q      <= lvl_d;
            wd_q       <= wd_d;
            ipl_q      <= ipl_d;
            vpa_q      <= vpa_d;
            iack_n_q   <= iack_n_d;
            iack_cyc_q <= iack_cyc_d;
            berr_q     <= berr_d;
        end
    end

    assign bus.IPL      = ipl_q;
    assign bus.VPA      = vpa_q;
    assign bus.IACK_N   = iack_n_q;
    assign bus.IACK_CYC = iack_cyc_q;
    assign bus.BERR     = berr_q;

endmodule

`default_nettype wire
